// File: rtl/reorder_buffer_if.sv
// Decode, writeback, query and commit signals of the reorder buffer.
// Slave modport is the ROB itself; master modport is the surrounding core (or a bench).
// Signal names follow the core's established port naming.
interface reorder_buffer_if #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = $clog2(ROB_SIZE)
);
    logic             rob_full;
    logic [IDX_W-1:0] rob_tail_idx;

    logic             de_in_en;
    logic [1:0]       de_type;
    logic [4:0]       de_rd;
    logic             de_pred_jump;
    logic [31:0]      de_alt_pc;

    logic             rs_in_en;
    logic [IDX_W-1:0] rs_rob_idx_in;
    logic [31:0]      rs_val_in;
    logic             lsb_in_en;
    logic [IDX_W-1:0] lsb_rob_idx_in;
    logic [31:0]      lsb_val_in;

    logic [IDX_W-1:0] qj_idx_in;
    logic [IDX_W-1:0] qk_idx_in;
    logic             qj_ready;
    logic             qk_ready;
    logic [31:0]      qj_val;
    logic [31:0]      qk_val;

    logic             cm_reg_en;
    logic [4:0]       cm_rd;
    logic [31:0]      cm_val;
    logic [IDX_W-1:0] cm_rob_idx;
    logic             cm_store_en;
    logic [IDX_W-1:0] cm_store_idx;
    logic             roll_back;
    logic [31:0]      roll_back_pc;

    modport slave (
        input  de_in_en, de_type, de_rd, de_pred_jump, de_alt_pc,
        input  rs_in_en, rs_rob_idx_in, rs_val_in,
        input  lsb_in_en, lsb_rob_idx_in, lsb_val_in,
        input  qj_idx_in, qk_idx_in,
        output rob_full, rob_tail_idx,
        output qj_ready, qk_ready, qj_val, qk_val,
        output cm_reg_en, cm_rd, cm_val, cm_rob_idx,
        output cm_store_en, cm_store_idx, roll_back, roll_back_pc
    );

    modport master (
        output de_in_en, de_type, de_rd, de_pred_jump, de_alt_pc,
        output rs_in_en, rs_rob_idx_in, rs_val_in,
        output lsb_in_en, lsb_rob_idx_in, lsb_val_in,
        output qj_idx_in, qk_idx_in,
        input  rob_full, rob_tail_idx,
        input  qj_ready, qk_ready, qj_val, qk_val,
        input  cm_reg_en, cm_rd, cm_val, cm_rob_idx,
        input  cm_store_en, cm_store_idx, roll_back, roll_back_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, accepts out-of-order writebacks, commits one entry per cycle.
// Latency: writeback at edge N on the head entry -> commit pulse visible the cycle after edge N+1; queries are combinational.
// Backpressure: rob_full (registered count only) blocks allocation; rdy_in low freezes all state and clears pulses.
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  logic           clk,
    input  logic           rst_in,
    input  logic           rdy_in,
    reorder_buffer_if.slave rob
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [1:0] TY_STORE  = 2'd1;
    localparam logic [1:0] TY_BRANCH = 2'd2;

    // Per-entry storage
    logic [ROB_SIZE-1:0] busy_q, ready_q, pred_q;
    logic [1:0]          type_q   [ROB_SIZE];
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [31:0]         alt_pc_q [ROB_SIZE];
    logic [31:0]         val_q    [ROB_SIZE];

    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    // Registered commit/flush outputs
    logic             cm_reg_en_q, cm_store_en_q, rb_q;
    logic [4:0]       cm_rd_q;
    logic [31:0]      cm_val_q, rb_pc_q;
    logic [IDX_W-1:0] cm_rob_idx_q, cm_store_idx_q;

    logic full, active, do_alloc, do_rs_wb, do_lsb_wb, do_commit, mispredict;

    assign full       = (count_q == CNT_W'(ROB_SIZE));
    // A flush pulse cycle behaves like a bubble: the new stream starts after it.
    assign active     = rdy_in && !rb_q;
    assign do_alloc   = active && rob.de_in_en && !full;
    assign do_rs_wb   = active && rob.rs_in_en  && busy_q[rob.rs_rob_idx_in];
    assign do_lsb_wb  = active && rob.lsb_in_en && busy_q[rob.lsb_rob_idx_in];
    assign do_commit  = active && busy_q[head_q] && ready_q[head_q];
    assign mispredict = do_commit && (type_q[head_q] == TY_BRANCH)
                        && (val_q[head_q][0] != pred_q[head_q]);

    // Control state: pointers, occupancy, busy/ready flags and commit/flush pulses
    always_ff @(posedge clk) begin
        if (rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            cm_reg_en_q    <= 1'b0;
            cm_rd_q        <= '0;
            cm_val_q       <= '0;
            cm_rob_idx_q   <= '0;
            cm_store_en_q  <= 1'b0;
            cm_store_idx_q <= '0;
            rb_q           <= 1'b0;
            rb_pc_q        <= '0;
        end else begin
            cm_reg_en_q    <= 1'b0;
            cm_rd_q        <= '0;
            cm_val_q       <= '0;
            cm_rob_idx_q   <= '0;
            cm_store_en_q  <= 1'b0;
            cm_store_idx_q <= '0;
            rb_q           <= 1'b0;
            rb_pc_q        <= '0;
            if (mispredict) begin
                busy_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                rb_q    <= 1'b1;
                rb_pc_q <= alt_pc_q[head_q];
            end else begin
                if (do_alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    tail_q          <= tail_q + IDX_W'(1);
                end
                if (do_rs_wb)  ready_q[rob.rs_rob_idx_in]  <= 1'b1;
                if (do_lsb_wb) ready_q[rob.lsb_rob_idx_in] <= 1'b1;
                if (do_commit) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + IDX_W'(1);
                    if (type_q[head_q] == TY_STORE) begin
                        cm_store_en_q  <= 1'b1;
                        cm_store_idx_q <= head_q;
                    end else if (type_q[head_q] != TY_BRANCH) begin
                        cm_reg_en_q  <= 1'b1;
                        cm_rd_q      <= rd_q[head_q];
                        cm_val_q     <= val_q[head_q];
                        cm_rob_idx_q <= head_q;
                    end
                end
                count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
            end
        end
    end

    // Entry payload: only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            type_q[tail_q]   <= rob.de_type;
            rd_q[tail_q]     <= rob.de_rd;
            pred_q[tail_q]   <= rob.de_pred_jump;
            alt_pc_q[tail_q] <= rob.de_alt_pc;
        end
        if (do_rs_wb)  val_q[rob.rs_rob_idx_in]  <= rob.rs_val_in;
        if (do_lsb_wb) val_q[rob.lsb_rob_idx_in] <= rob.lsb_val_in;
    end

    logic        qj_rdy, qk_rdy;
    logic [31:0] qj_v, qk_v;

    // Operand query: stored result first, then same-cycle writeback bypass (ALU over LSB)
    always_comb begin
        qj_rdy = 1'b0;
        qj_v   = '0;
        qk_rdy = 1'b0;
        qk_v   = '0;
        if (busy_q[rob.qj_idx_in] && ready_q[rob.qj_idx_in]) begin
            qj_rdy = 1'b1;
            qj_v   = val_q[rob.qj_idx_in];
        end else if (rob.rs_in_en && rob.rs_rob_idx_in == rob.qj_idx_in) begin
            qj_rdy = 1'b1;
            qj_v   = rob.rs_val_in;
        end else if (rob.lsb_in_en && rob.lsb_rob_idx_in == rob.qj_idx_in) begin
            qj_rdy = 1'b1;
            qj_v   = rob.lsb_val_in;
        end
        if (busy_q[rob.qk_idx_in] && ready_q[rob.qk_idx_in]) begin
            qk_rdy = 1'b1;
            qk_v   = val_q[rob.qk_idx_in];
        end else if (rob.rs_in_en && rob.rs_rob_idx_in == rob.qk_idx_in) begin
            qk_rdy = 1'b1;
            qk_v   = rob.rs_val_in;
        end else if (rob.lsb_in_en && rob.lsb_rob_idx_in == rob.qk_idx_in) begin
            qk_rdy = 1'b1;
            qk_v   = rob.lsb_val_in;
        end
    end

    assign rob.rob_full     = full;
    assign rob.rob_tail_idx = tail_q;
    assign rob.qj_ready     = qj_rdy;
    assign rob.qj_val       = qj_v;
    assign rob.qk_ready     = qk_rdy;
    assign rob.qk_val       = qk_v;
    assign rob.cm_reg_en    = cm_reg_en_q;
    assign rob.cm_rd        = cm_rd_q;
    assign rob.cm_val       = cm_val_q;
    assign rob.cm_rob_idx   = cm_rob_idx_q;
    assign rob.cm_store_en  = cm_store_en_q;
    assign rob.cm_store_idx = cm_store_idx_q;
    assign rob.roll_back    = rb_q;
    assign rob.roll_back_pc = rb_pc_q;
endmodule
